vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing generator. It produces the pixel-rate enable, horizontal/vertical counters, sync pulses, the active-video flag, and line/frame markers that feed the VGA controller's pixel pipeline. It generalises the fixed 640x480 sync logic: resolution and porches, clock division, and sync polarity are all set by parameters. It also adds a run/drain/idle control FSM and a frame counter.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- CLK_DIV, 2, system clocks per pixel, ≥1 (50 MHz → 25 MHz pixel rate)
- HS_POL / VS_POL, 0 / 0, active level of hsync / vsync
- CNT_W, 10, counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- FRAME_W, 8, frame counter width
- clock  in  1  system clock; all logic is rising-edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run request, sampled every clock
- pixel_tick  out  1  one-clock pulse per pixel period
- pixel_x  out  CNT_W  horizontal counter, full range 0..H_TOTAL-1 (not clamped to active area)
- pixel_y  out  CNT_W  vertical counter, 0..V_TOTAL-1
- hsync / vsync  out  1  sync outputs at the configured polarity
- video_on  out  1  high inside the active area
- line_start  out  1  one-clock pulse when pixel_x becomes 0
- frame_start  out  1  one-clock pulse when (pixel_x, pixel_y) becomes (0,0)
- frame_count  out  FRAME_W  completed-frame-start count; wraps modulo 2^FRAME_W
- running  out  1  high in RUN or DRAIN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way from the vertical parameters.
- **FSM states: IDLE, RUN, DRAIN.**
  - IDLE: divider, counters and markers are held at 0. hsync=~HS_POL, vsync=~VS_POL, video_on=0, running=0.
  - IDLE & enable=1 → RUN.
    - Entry edge: counters=(0,0), frame_start=1, line_start=1, frame_count+1, running=1, video_on=1. Divider restarts at 0.
  - RUN & enable=0 → DRAIN. The counters continue unchanged.
  - DRAIN & enable=1 → RUN with no discontinuity.
  - DRAIN: on the tick at (H_TOTAL-1, V_TOTAL-1) the FSM goes to IDLE instead of wrapping. No frame_start pulse and no frame_count increment on that edge.
- **Divider:** div counts 0..CLK_DIV-1 while running. pixel_tick=1 on the clock where div==CLK_DIV-1. With CLK_DIV=1, pixel_tick stays high continuously while running.
- **Counters:**
  - On each pixel_tick, pixel_x+1.
  - At pixel_x = H_TOTAL-1, pixel_x wraps to 0 and pixel_y+1.
  - At pixel_y = V_TOTAL-1, pixel_y wraps to 0.
- **Decode:**
  - hsync is active when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
  - video_on = (x<H_ACTIVE) & (y<V_ACTIVE) & running.
- **Markers:**
  - line_start pulses on every edge where x becomes 0.
  - frame_start pulses where both x and y become 0.
  - frame_count increments with frame_start.

## Timing
- All outputs are registered and decoded from next-state counter values. hsync, vsync, video_on and the markers therefore change on the same edge as pixel_x/pixel_y and are always coherent with them. Zero added latency relative to the coordinates.
- Reset is asynchronous: while reset=0, all outputs take their IDLE values immediately, with no clock edge required. frame_count=0 and FSM=IDLE.
- After reset release, the first pixel_tick occurs CLK_DIV clocks after the RUN entry edge.
- Line period = H_TOTAL·CLK_DIV clocks. Frame period = H_TOTAL·V_TOTAL·CLK_DIV clocks.
- frame_count wraps from 2^FRAME_W-1 to 0 with no flag.
- enable toggles that leave and re-enter within the same DRAIN interval have no visible effect.

## Test plan
1. **Reset values.** Hold reset=0 and toggle the clock. Required: hsync=1, vsync=1, video_on=0, pixel_x=pixel_y=0, frame_count=0, running=0, pixel_tick=0.
2. **Default timing.** Set enable=1.
   - hsync low for 192 clocks, starting at pixel_x=656.
   - Line period 1600 clocks.
   - video_on high for 1280 clocks per line on lines 0..479, and 0 on lines 480..524.
   - vsync low on lines 490..491.
   - frame_start every 840000 clocks.
3. **Tiny instance.** Parameters: H=4/1/2/1, V=3/1/1/1, CLK_DIV=1, FRAME_W=2.
   - Exact pixel_x sequence 0..7 repeating.
   - hsync active at x=5,6. vsync active at y=4.
   - frame_count reads 1,2,3,0 on successive frame_starts.
4. **Drain.** Drop enable at pixel_y=100.
   - The frame completes and FSM reaches IDLE after the tick at (799,524). No frame_start is issued and frame_count is unchanged.
   - Repeat, re-raising enable at y=200: frames continue with no gap.
5. **Async reset mid-line.** Pull reset low at pixel_x=300, between clock edges. Required: all outputs reach IDLE values before the next edge. After release with enable=1, RUN is re-entered and frame_count=1.
6. **Polarity.** Set HS_POL=1, VS_POL=1. Required: hsync/vsync idle low and pulse high at the same positions as in test 2.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator with a run/drain/idle control FSM.
// Produces the pixel-rate enable, free-running raster counters, sync pulses
// at a configurable polarity, the active-video flag, line/frame markers and a
// wrapping frame counter. Every output is registered and decoded from the
// next-state raster position, so all of them change on the same edge as
// pixel_x/pixel_y.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run request, sampled every clock
//   pixel_tick   out  one-clock pulse per pixel period (steady high if CLK_DIV=1)
//   pixel_x      out  horizontal counter, 0..H_TOTAL-1
//   pixel_y      out  vertical counter, 0..V_TOTAL-1
//   hsync/vsync  out  sync outputs, active level HS_POL/VS_POL
//   video_on     out  high inside the visible area while running
//   line_start   out  pulse on the edge where pixel_x becomes 0
//   frame_start  out  pulse on the edge where (pixel_x,pixel_y) becomes (0,0)
//   frame_count  out  count of frame starts, wraps modulo 2^FRAME_W
//   running      out  high in RUN or DRAIN
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               pixel_tick,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [CNT_W-1:0]   pixel_y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count,
  output logic               running
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_nxt;
  logic [CNT_W-1:0]   x_nxt;
  logic [CNT_W-1:0]   y_nxt;
  logic [FRAME_W-1:0] fc_nxt;
  logic               ls_nxt;
  logic               fs_nxt;
  logic               run_nxt;
  logic               tick_nxt;
  logic               hs_nxt;
  logic               vs_nxt;
  logic               von_nxt;
  logic               tick_now;
  logic               end_of_frame;

  // Pixel advance happens on the edge that closes a divider period.
  assign tick_now     = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign end_of_frame = (pixel_x == X_LAST) && (pixel_y == Y_LAST);

  // Next-state: FSM, divider, raster counters, markers, then output decode.
  always_comb begin
    state_nxt = state_q;
    div_nxt   = div_q;
    x_nxt     = pixel_x;
    y_nxt     = pixel_y;
    fc_nxt    = frame_count;
    ls_nxt    = 1'b0;
    fs_nxt    = 1'b0;
    run_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    hs_nxt    = ~HS_POL;
    vs_nxt    = ~VS_POL;
    von_nxt   = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_nxt = '0;
        x_nxt   = '0;
        y_nxt   = '0;
        // Entering RUN lands on (0,0), which is itself a new frame.
        if (enable) begin
          state_nxt = S_RUN;
          ls_nxt    = 1'b1;
          fs_nxt    = 1'b1;
          fc_nxt    = frame_count + FRAME_W'(1);
        end
      end

      S_RUN, S_DRAIN: begin
        state_nxt = enable ? S_RUN : S_DRAIN;
        div_nxt   = tick_now ? '0 : div_q + DIV_W'(1);
        if (tick_now) begin
          if (pixel_x == X_LAST) begin
            x_nxt  = '0;
            ls_nxt = 1'b1;
            if (pixel_y == Y_LAST) begin
              y_nxt  = '0;
              fs_nxt = 1'b1;
              fc_nxt = frame_count + FRAME_W'(1);
            end else begin
              y_nxt = pixel_y + CNT_W'(1);
            end
          end else begin
            x_nxt = pixel_x + CNT_W'(1);
          end
          // A draining frame ends in IDLE instead of wrapping into a new one.
          if ((state_q == S_DRAIN) && !enable && end_of_frame) begin
            state_nxt = S_IDLE;
            div_nxt   = '0;
            ls_nxt    = 1'b0;
            fs_nxt    = 1'b0;
            fc_nxt    = frame_count;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
        div_nxt   = '0;
        x_nxt     = '0;
        y_nxt     = '0;
      end
    endcase

    // Decode from the next-state position so outputs stay coherent with it.
    run_nxt  = (state_nxt != S_IDLE);
    tick_nxt = run_nxt && (div_nxt == DIV_LAST);
    hs_nxt   = (run_nxt && (32'(x_nxt) >= HS_START) && (32'(x_nxt) < HS_END))
               ? HS_POL : ~HS_POL;
    vs_nxt   = (run_nxt && (32'(y_nxt) >= VS_START) && (32'(y_nxt) < VS_END))
               ? VS_POL : ~VS_POL;
    von_nxt  = run_nxt && (32'(x_nxt) < H_ACTIVE) && (32'(y_nxt) < V_ACTIVE);
  end

  // State and output registers; reset forces IDLE values immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      pixel_tick  <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      div_q       <= div_nxt;
      pixel_tick  <= tick_nxt;
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      hsync       <= hs_nxt;
      vsync       <= vs_nxt;
      video_on    <= von_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      frame_count <= fc_nxt;
      running     <= run_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Bench for vga_timing_gen: a default 640x480 instance, the same geometry
// with inverted sync polarity, and a tiny 8x6 instance with CLK_DIV=1 and a
// 2-bit frame counter used for frame wrap and drain sequences.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk;
  logic rst_n_def, rst_n_tiny;
  logic en_def, en_tiny;

  logic       d_tick, d_hs, d_vs, d_von, d_ls, d_fs, d_run;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       p_tick, p_hs, p_vs, p_von, p_ls, p_fs, p_run;
  logic [9:0] p_x, p_y;
  logic [7:0] p_fc;
  logic       t_tick, t_hs, t_vs, t_von, t_ls, t_fs, t_run;
  logic [9:0] t_x, t_y;
  logic [1:0] t_fc;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
    bit tick;
    bit hs;
    bit vs;
    bit von;
    bit ls;
    bit fs;
    int frames;
  } exp_t;

  typedef struct {
    int t;
    int x;
    int y;
    bit hs;
    bit vs;
    bit von;
    bit fs;
    int fc;
  } vec_t;

  exp_t q_d[$];
  exp_t q_t[$];
  vec_t tbl[17];

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n_def), .enable(en_def),
    .pixel_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc), .running(d_run)
  );

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) dut_pol (
    .clk(clk), .rst_n(rst_n_def), .enable(en_def),
    .pixel_tick(p_tick), .pixel_x(p_x), .pixel_y(p_y),
    .hsync(p_hs), .vsync(p_vs), .video_on(p_von),
    .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc), .running(p_run)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .FRAME_W(2)
  ) dut_tiny (
    .clk(clk), .rst_n(rst_n_tiny), .enable(en_tiny),
    .pixel_tick(t_tick), .pixel_x(t_x), .pixel_y(t_y),
    .hsync(t_hs), .vsync(t_vs), .video_on(t_von),
    .line_start(t_ls), .frame_start(t_fs), .frame_count(t_fc), .running(t_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [31:0] act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Analytic raster position t clocks after the RUN entry edge.
  function automatic exp_t model(input int t, input int d,
                                 input int ha, input int hf, input int hw, input int hb,
                                 input int va, input int vf, input int vw, input int vb,
                                 input bit hp, input bit vp);
    exp_t e;
    int ht, vt, pix;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    pix = t / d;
    e.x = pix % ht;
    e.y = (pix / ht) % vt;
    e.tick = ((t % d) == d - 1);
    e.hs = (e.x >= ha + hf && e.x < ha + hf + hw) ? hp : ~hp;
    e.vs = (e.y >= va + vf && e.y < va + vf + vw) ? vp : ~vp;
    e.von = (e.x < ha) && (e.y < va);
    e.ls = ((t % (ht * d)) == 0);
    e.fs = ((t % (ht * vt * d)) == 0);
    e.frames = t / (ht * vt * d) + 1;
    return e;
  endfunction

  function automatic exp_t m_def(input int t, input bit pol);
    return model(t, 2, 640, 16, 96, 48, 480, 10, 2, 33, pol, pol);
  endfunction

  function automatic exp_t m_tiny(input int t);
    return model(t, 1, 4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
  endfunction

  // One clock of the default pair: expectation queued, then checked at negedge.
  task automatic def_step(input int tn);
    exp_t e, ep;
    q_d.push_back(m_def(tn, 1'b0));
    @(negedge clk);
    e  = q_d.pop_front();
    ep = m_def(tn, 1'b1);
    cmp("def_x", 32'(d_x), e.x);
    cmp("def_y", 32'(d_y), e.y);
    cmp("def_tick", 32'(d_tick), int'(e.tick));
    cmp("def_hsync", 32'(d_hs), int'(e.hs));
    cmp("def_vsync", 32'(d_vs), int'(e.vs));
    cmp("def_video_on", 32'(d_von), int'(e.von));
    cmp("def_line_start", 32'(d_ls), int'(e.ls));
    cmp("def_frame_start", 32'(d_fs), int'(e.fs));
    cmp("def_running", 32'(d_run), 1);
    cmp("def_frame_count", 32'(d_fc), e.frames % 256);
    cmp("pol_hsync", 32'(p_hs), int'(ep.hs));
    cmp("pol_vsync", 32'(p_vs), int'(ep.vs));
  endtask

  task automatic tiny_step(input int tn, input int base);
    exp_t e;
    q_t.push_back(m_tiny(tn));
    @(negedge clk);
    e = q_t.pop_front();
    cmp("tiny_x", 32'(t_x), e.x);
    cmp("tiny_y", 32'(t_y), e.y);
    cmp("tiny_tick", 32'(t_tick), int'(e.tick));
    cmp("tiny_hsync", 32'(t_hs), int'(e.hs));
    cmp("tiny_vsync", 32'(t_vs), int'(e.vs));
    cmp("tiny_video_on", 32'(t_von), int'(e.von));
    cmp("tiny_line_start", 32'(t_ls), int'(e.ls));
    cmp("tiny_frame_start", 32'(t_fs), int'(e.fs));
    cmp("tiny_running", 32'(t_run), 1);
    cmp("tiny_frame_count", 32'(t_fc), (base + e.frames) % 4);
  endtask

  initial begin
    int tt, guard, hs_low, first_hs_x, von_cnt, ls_cnt, last_ls, ls_gap;

    // tiny instance: {t, x, y, hsync, vsync, video_on, frame_start, frame_count}
    tbl[0]  = '{0,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[1]  = '{3,   3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[2]  = '{4,   4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[3]  = '{5,   5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{6,   6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[5]  = '{7,   7, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{8,   0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    tbl[7]  = '{20,  4, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{24,  0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{37,  5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{38,  6, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{40,  0, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{47,  7, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[13] = '{48,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 2};
    tbl[14] = '{96,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 3};
    tbl[15] = '{144, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[16] = '{149, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0};

    rst_n_def = 1'b0; rst_n_tiny = 1'b0; en_def = 1'b0; en_tiny = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values while clocks run.
    cmp("rst_hsync", 32'(d_hs), 1);
    cmp("rst_vsync", 32'(d_vs), 1);
    cmp("rst_video_on", 32'(d_von), 0);
    cmp("rst_x", 32'(d_x), 0);
    cmp("rst_y", 32'(d_y), 0);
    cmp("rst_frame_count", 32'(d_fc), 0);
    cmp("rst_running", 32'(d_run), 0);
    cmp("rst_tick", 32'(d_tick), 0);
    cmp("rst_pol_hsync", 32'(p_hs), 0);
    cmp("rst_pol_vsync", 32'(p_vs), 0);
    cmp("rst_tiny_running", 32'(t_run), 0);
    cmp("rst_tiny_fc", 32'(t_fc), 0);

    rst_n_def = 1'b1; rst_n_tiny = 1'b1;
    repeat (2) @(negedge clk);
    cmp("idle_running", 32'(d_run), 0);
    cmp("idle_tick", 32'(d_tick), 0);
    cmp("idle_frame_start", 32'(d_fs), 0);

    // Default timing over two full lines.
    en_def = 1'b1;
    hs_low = 0; first_hs_x = -1; von_cnt = 0; ls_cnt = 0; last_ls = -1; ls_gap = 0;
    for (int i = 0; i < 3400; i++) begin
      def_step(i);
      if (i < 1600) begin
        if (d_hs == 1'b0) begin
          if (first_hs_x < 0) first_hs_x = int'(d_x);
          hs_low++;
        end
        if (d_von == 1'b1) von_cnt++;
      end
      if (d_ls == 1'b1) begin
        ls_cnt++;
        if (last_ls >= 0) ls_gap = i - last_ls;
        last_ls = i;
      end
    end
    cmp("hsync_low_clocks", 32'(hs_low), 192);
    cmp("hsync_first_x", 32'(first_hs_x), 656);
    cmp("video_on_clocks", 32'(von_cnt), 1280);
    cmp("line_start_count", 32'(ls_cnt), 3);
    cmp("line_period", 32'(ls_gap), 1600);

    // Async reset between edges in the middle of a line.
    tt = 3399; guard = 0;
    while (int'(d_x) != 300 && guard < 2000) begin
      tt++;
      def_step(tt);
      guard++;
    end
    cmp("mid_line_x", 32'(d_x), 300);
    #2;
    rst_n_def = 1'b0;
    #1;
    cmp("arst_x", 32'(d_x), 0);
    cmp("arst_y", 32'(d_y), 0);
    cmp("arst_hsync", 32'(d_hs), 1);
    cmp("arst_vsync", 32'(d_vs), 1);
    cmp("arst_video_on", 32'(d_von), 0);
    cmp("arst_tick", 32'(d_tick), 0);
    cmp("arst_line_start", 32'(d_ls), 0);
    cmp("arst_frame_start", 32'(d_fs), 0);
    cmp("arst_frame_count", 32'(d_fc), 0);
    cmp("arst_running", 32'(d_run), 0);
    cmp("arst_pol_hsync", 32'(p_hs), 0);
    cmp("arst_pol_vsync", 32'(p_vs), 0);
    @(negedge clk);
    rst_n_def = 1'b1;
    @(negedge clk);
    cmp("rerun_running", 32'(d_run), 1);
    cmp("rerun_x", 32'(d_x), 0);
    cmp("rerun_y", 32'(d_y), 0);
    cmp("rerun_frame_start", 32'(d_fs), 1);
    cmp("rerun_frame_count", 32'(d_fc), 1);
    cmp("rerun_video_on", 32'(d_von), 1);
    en_def = 1'b0;
    rst_n_def = 1'b0;

    // Tiny instance: table of raster points, every clock also scoreboarded.
    en_tiny = 1'b1;
    tt = -1;
    for (int k = 0; k < 17; k++) begin
      while (tt < tbl[k].t) begin
        tt++;
        tiny_step(tt, 0);
      end
      cmp("tbl_x", 32'(t_x), tbl[k].x);
      cmp("tbl_y", 32'(t_y), tbl[k].y);
      cmp("tbl_hsync", 32'(t_hs), int'(tbl[k].hs));
      cmp("tbl_vsync", 32'(t_vs), int'(tbl[k].vs));
      cmp("tbl_video_on", 32'(t_von), int'(tbl[k].von));
      cmp("tbl_frame_start", 32'(t_fs), int'(tbl[k].fs));
      cmp("tbl_frame_count", 32'(t_fc), tbl[k].fc);
    end

    // Drain: drop enable on line 1, frame finishes then goes idle.
    guard = 0;
    while (int'(t_y) != 1 && guard < 100) begin
      tt++;
      tiny_step(tt, 0);
      guard++;
    end
    cmp("drain_start_y", 32'(t_y), 1);
    en_tiny = 1'b0;
    while (tt < 191) begin
      tt++;
      tiny_step(tt, 0);
    end
    @(negedge clk);
    cmp("drain_running", 32'(t_run), 0);
    cmp("drain_x", 32'(t_x), 0);
    cmp("drain_y", 32'(t_y), 0);
    cmp("drain_frame_start", 32'(t_fs), 0);
    cmp("drain_line_start", 32'(t_ls), 0);
    cmp("drain_frame_count", 32'(t_fc), 0);
    cmp("drain_tick", 32'(t_tick), 0);
    cmp("drain_hsync", 32'(t_hs), 1);
    cmp("drain_video_on", 32'(t_von), 0);
    repeat (3) @(negedge clk);
    cmp("idle_hold_running", 32'(t_run), 0);
    cmp("idle_hold_frame_count", 32'(t_fc), 0);

    // Re-enter RUN, then drain and re-raise within the same frame.
    en_tiny = 1'b1;
    tt = 0;
    tiny_step(tt, 0);
    while (tt < 8) begin
      tt++;
      tiny_step(tt, 0);
    end
    en_tiny = 1'b0;
    while (tt < 24) begin
      tt++;
      tiny_step(tt, 0);
    end
    en_tiny = 1'b1;
    while (tt < 60) begin
      tt++;
      tiny_step(tt, 0);
    end
    cmp("nogap_frame_count", 32'(t_fc), 2);
    cmp("nogap_running", 32'(t_run), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
